matrix_result_streamer: RTL

Downstream stage of the MIPS 3x3 matrix-multiplication core. Watches the core's program counter; when it reaches the halt address, snapshots the nine result words `d11`..`d33` and streams them out one word per handshake in row-major order on a valid/ready interface. It replaces bench-side `$display` polling as the defined way the product matrix leaves the design.

---
 rtl/matrix_stream_pkg.sv | 23 ++
 rtl/result_snapshot_reg.sv | 81 ++++++++
 rtl/matrix_result_streamer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/matrix_stream_pkg.sv
// Shared types and sizes for the matrix result streamer.
// MATRIX_STREAM_CHECKSUM_EN appends a checksum word to every frame.
package matrix_stream_pkg;

    localparam int unsigned N_RESULT_WORDS  = 9;
    localparam int unsigned IDX_W           = 4;
    localparam int unsigned HALT_PC_DEFAULT = 356;

`ifdef MATRIX_STREAM_CHECKSUM_EN
    localparam int unsigned N_FRAME_WORDS = N_RESULT_WORDS + 1;
`else
    localparam int unsigned N_FRAME_WORDS = N_RESULT_WORDS;
`endif

    localparam int unsigned LAST_IDX = N_FRAME_WORDS - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/result_snapshot_reg.sv
// Nine-word result snapshot with load enable and an indexed read port.
// MATRIX_STREAM_CHECKSUM_EN adds a tenth word holding the sum taken at load time.
module result_snapshot_reg
    import matrix_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d11,
    input  logic [DATA_W-1:0] d12,
    input  logic [DATA_W-1:0] d13,
    input  logic [DATA_W-1:0] d21,
    input  logic [DATA_W-1:0] d22,
    input  logic [DATA_W-1:0] d23,
    input  logic [DATA_W-1:0] d31,
    input  logic [DATA_W-1:0] d32,
    input  logic [DATA_W-1:0] d33,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data_c
);

    logic [DATA_W-1:0] word_in [N_RESULT_WORDS];
    logic [DATA_W-1:0] snap_q  [N_FRAME_WORDS];
    logic [DATA_W-1:0] snap_d  [N_FRAME_WORDS];

    assign word_in[0] = d11;
    assign word_in[1] = d12;
    assign word_in[2] = d13;
    assign word_in[3] = d21;
    assign word_in[4] = d22;
    assign word_in[5] = d23;
    assign word_in[6] = d31;
    assign word_in[7] = d32;
    assign word_in[8] = d33;

`ifdef MATRIX_STREAM_CHECKSUM_EN
    logic [DATA_W-1:0] sum_c;

    // Checksum wraps modulo 2^DATA_W.
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < N_RESULT_WORDS; i++) begin
            sum_c = sum_c + word_in[i];
        end
    end
`endif

    always_comb begin
        for (int unsigned i = 0; i < N_RESULT_WORDS; i++) begin
            snap_d[i] = load ? word_in[i] : snap_q[i];
        end
`ifdef MATRIX_STREAM_CHECKSUM_EN
        snap_d[N_RESULT_WORDS] = load ? sum_c : snap_q[N_RESULT_WORDS];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_FRAME_WORDS; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_FRAME_WORDS; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

    // Reads the next-state snapshot so the top can register the word on the capture edge.
    always_comb begin
        rd_data_c = '0;
        for (int unsigned i = 0; i < N_FRAME_WORDS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data_c = snap_d[i];
            end
        end
    end

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures the 3x3 product matrix when the core halts and streams it row-major on valid/ready.
// MATRIX_STREAM_CHECKSUM_EN appends a modular checksum word (idx 9).
module matrix_result_streamer
    import matrix_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned HALT_PC = HALT_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] d11,
    input  logic [DATA_W-1:0] d12,
    input  logic [DATA_W-1:0] d13,
    input  logic [DATA_W-1:0] d21,
    input  logic [DATA_W-1:0] d22,
    input  logic [DATA_W-1:0] d23,
    input  logic [DATA_W-1:0] d31,
    input  logic [DATA_W-1:0] d32,
    input  logic [DATA_W-1:0] d33,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load_c;
    logic              at_halt_c;
    logic              xfer_c;
    logic [DATA_W-1:0] rd_data_c;

    assign at_halt_c = (pc == PC_W'(HALT_PC));
    assign xfer_c    = out_valid_q && out_ready;

    result_snapshot_reg #(
        .DATA_W (DATA_W)
    ) u_snapshot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .d11       (d11),
        .d12       (d12),
        .d13       (d13),
        .d21       (d21),
        .d22       (d22),
        .d23       (d23),
        .d31       (d31),
        .d32       (d32),
        .d33       (d33),
        .rd_idx    (idx_d),
        .rd_data_c (rd_data_c)
    );

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (at_halt_c) begin
                    load_c  = 1'b1;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer_c) begin
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                if (!at_halt_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == STREAM);
        busy_d      = (state_d == STREAM);
        done_d      = (state_d == DONE);
        out_last_d  = out_valid_d && (idx_d == IDX_W'(LAST_IDX));
        out_data_d  = out_valid_d ? rd_data_c : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_idx   = idx_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
